// File: rtl/muldiv_pkg.sv
// Shared constants for the sequential multiply/divide unit: op encodings, FSM states, div-by-zero quotient.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package muldiv_pkg;

    // Operation select on the op input.
    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

    // Control FSM states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Quotient reported for a zero divisor; callers truncate to their data width.
    localparam logic [63:0] DIV0_QUOT = '1;

endpackage

// File: rtl/seq_mul_div_twos_mag.sv
// Conditional two's-complement negate: magnitude of a negative value, or sign application to a magnitude.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows the inputs.
module twos_mag #(
    parameter int W = 32
) (
    input  logic [W-1:0] value,
    input  logic         sign_en,
    output logic [W-1:0] mag
);

    // Negate when sign_en is set; the caller supplies a width that holds the most negative input's magnitude.
    always_comb begin
        mag = sign_en ? -value : value;
    end

endmodule

// File: rtl/seq_mul_div.sv
// Signed multi-cycle MUL/DIV for ZHigh/ZLow: one shift-add or restoring-divide step per clock. Optional MULDIV_DIV0_FLAG_EN adds div_by_zero.
// Latency: done pulses in the DATA_WIDTH+2'th cycle after the start edge; results hold until the next operation.
// Backpressure: none; start is only accepted while idle and is silently dropped while busy.
module seq_mul_div
    import muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  start,
    input  logic                  op,
    input  logic [DATA_WIDTH-1:0] operand_a,
    input  logic [DATA_WIDTH-1:0] operand_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result_hi,
    output logic [DATA_WIDTH-1:0] result_lo
`ifdef MULDIV_DIV0_FLAG_EN
    ,
    output logic                  div_by_zero
`endif
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W) + 1;

    state_t           state;
    state_t           state_nxt;
    logic             op_r;
    logic             sign_a;
    logic             sign_b;
    logic             b_zero;
    logic [W:0]       mag_a;
    logic [W:0]       mag_b;
    logic [2*W-1:0]   acc;
    logic [CW-1:0]    cnt;

    logic [W:0]       a_abs;
    logic [W:0]       b_abs;
    logic             last_iter;
    logic [W:0]       mul_sum;
    logic [W:0]       div_trial;
    logic             div_ge;
    logic [W-1:0]     div_diff;
    logic [2*W-1:0]   acc_mul_nxt;
    logic [2*W-1:0]   acc_div_nxt;
    logic [2*W-1:0]   fix_in;
    logic [2*W-1:0]   fix_wide;
    logic [W-1:0]     fix_rem;

    // Operand magnitudes are one bit wider so the most negative value has a representable magnitude.
    twos_mag #(.W(W + 1)) u_mag_a (
        .value   ({operand_a[W-1], operand_a}),
        .sign_en (operand_a[W-1]),
        .mag     (a_abs)
    );

    twos_mag #(.W(W + 1)) u_mag_b (
        .value   ({operand_b[W-1], operand_b}),
        .sign_en (operand_b[W-1]),
        .mag     (b_abs)
    );

    // Product (MUL) or quotient (DIV) takes the XOR of the operand signs.
    assign fix_in = (op_r == OP_MUL) ? acc : {{W{1'b0}}, acc[W-1:0]};

    twos_mag #(.W(2 * W)) u_fix_wide (
        .value   (fix_in),
        .sign_en (sign_a ^ sign_b),
        .mag     (fix_wide)
    );

    // Remainder follows the dividend's sign.
    twos_mag #(.W(W)) u_fix_rem (
        .value   (acc[2*W-1:W]),
        .sign_en (sign_a),
        .mag     (fix_rem)
    );

    // One iteration of each algorithm; acc holds {upper, lower} halves shared by both.
    always_comb begin
        last_iter   = (cnt == CW'(W - 1));
        // MUL: add multiplicand into the upper half when the current multiplier bit is set, then shift right.
        mul_sum     = {1'b0, acc[2*W-1:W]} + (acc[0] ? mag_a : '0);
        acc_mul_nxt = {mul_sum, acc[W-1:1]};
        // DIV: shift next dividend bit into the partial remainder and subtract the divisor if it fits.
        div_trial   = {acc[2*W-1:W], acc[W-1]};
        div_ge      = (div_trial >= mag_b);
        div_diff    = div_trial[W-1:0] - mag_b[W-1:0];
        acc_div_nxt = {(div_ge ? div_diff : div_trial[W-1:0]), acc[W-2:0], div_ge};
    end

    // State register; clear returns to IDLE at once, even mid-operation.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (last_iter) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and sign-corrected result registers.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            op_r      <= 1'b0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            b_zero    <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            acc       <= '0;
            cnt       <= '0;
            result_hi <= '0;
            result_lo <= '0;
`ifdef MULDIV_DIV0_FLAG_EN
            div_by_zero <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r   <= op;
                        sign_a <= operand_a[W-1];
                        sign_b <= operand_b[W-1];
                        b_zero <= (operand_b == '0);
                        mag_a  <= a_abs;
                        mag_b  <= b_abs;
                        cnt    <= '0;
                        // MUL walks the multiplier bits; DIV walks the dividend bits.
                        acc    <= (op == OP_MUL) ? {{W{1'b0}}, b_abs[W-1:0]}
                                                 : {{W{1'b0}}, a_abs[W-1:0]};
                    end
                end
                CALC: begin
                    acc <= (op_r == OP_MUL) ? acc_mul_nxt : acc_div_nxt;
                    cnt <= cnt + CW'(1);
                end
                FIX: begin
                    if (op_r == OP_MUL) begin
                        result_hi <= fix_wide[2*W-1:W];
                        result_lo <= fix_wide[W-1:0];
                    end else begin
                        result_hi <= fix_rem;
                        result_lo <= b_zero ? W'(DIV0_QUOT) : fix_wide[W-1:0];
                    end
`ifdef MULDIV_DIV0_FLAG_EN
                    div_by_zero <= (op_r == OP_DIV) && b_zero;
`endif
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mul_div.sv
// Self-checking bench for seq_mul_div: directed corner cases, busy/reset handling and random operands against an arithmetic model.
// Latency expectation: done in cycle 34 after the start edge, busy over cycles 1..34.
// Backpressure: start pulses while busy must be ignored.
module tb_seq_mul_div;

    logic        clock = 1'b0;
    logic        clear;
    logic        start;
    logic        op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result_hi;
    logic [31:0] result_lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic        div_by_zero;
`endif

    int checks = 0;
    int errors = 0;

    seq_mul_div #(.DATA_WIDTH(32)) dut (
        .clock       (clock),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .operand_a   (operand_a),
        .operand_b   (operand_b),
        .busy        (busy),
        .done        (done),
        .result_hi   (result_hi),
        .result_lo   (result_lo)
`ifdef MULDIV_DIV0_FLAG_EN
        ,
        .div_by_zero (div_by_zero)
`endif
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Reference: signed arithmetic on 64-bit integers; returns {hi, lo}.
    function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        longint q;
        longint r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (o == 1'b0) begin
            p = sa * sb;
            return p;
        end
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Issue one operation, watch busy/done each cycle, check results and the return to idle.
    task automatic run_op(input logic o, input logic [31:0] a, input logic [31:0] b,
                          input string tag, input int pulse_at);
        logic [63:0] exp;
        bit          seen;
        int          c;
        exp = model(o, a, b);
        @(negedge clock);
        start = 1'b1; op = o; operand_a = a; operand_b = b;
        @(posedge clock); #1;
        // Operands are scrambled after the start edge; the unit must not care.
        start = 1'b0; op = ~o; operand_a = $urandom; operand_b = $urandom;
        seen = 1'b0;
        for (c = 1; c <= 40; c++) begin
            if (c == pulse_at) begin
                start = 1'b1; op = 1'($urandom); operand_a = $urandom; operand_b = $urandom;
            end else begin
                start = 1'b0;
            end
            if (c <= 34) check({tag, " busy"}, 64'(busy), 64'(1));
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clock); #1;
        end
        check({tag, " done cycle"}, 64'(seen ? c : -1), 64'(34));
        if (seen) begin
            check({tag, " hi"}, 64'(result_hi), 64'(exp[63:32]));
            check({tag, " lo"}, 64'(result_lo), 64'(exp[31:0]));
`ifdef MULDIV_DIV0_FLAG_EN
            check({tag, " div0 flag"}, 64'(div_by_zero), 64'((o == 1'b1) && (b == 32'h0)));
`endif
        end
        @(posedge clock); #1;
        start = 1'b0;
        check({tag, " done pulse"}, 64'(done), 64'(0));
        check({tag, " idle"}, 64'(busy), 64'(0));
        check({tag, " hold"}, {result_hi, result_lo}, exp);
    endtask

    logic [31:0] specials [5];
    logic [31:0] ra;
    logic [31:0] rb;
    int          active;

    initial begin
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;

        // Reset state
        clear = 1'b1; start = 1'b0; op = 1'b0; operand_a = '0; operand_b = '0;
        #12;
        check("reset busy", 64'(busy), 64'(0));
        check("reset done", 64'(done), 64'(0));
        check("reset result", {result_hi, result_lo}, 64'(0));
`ifdef MULDIV_DIV0_FLAG_EN
        check("reset flag", 64'(div_by_zero), 64'(0));
`endif
        @(negedge clock); clear = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("idle busy", 64'(busy), 64'(0));

        // Directed corner cases
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, "mul 7*-3", 0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, "mul min*min", 0);
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div -7/2", 0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div min/-1", 0);
        run_op(1'b1, 32'd5, 32'd0, "div 5/0", 0);
        run_op(1'b0, 32'd2, 32'd3, "mul 2*3 after div0", 0);
        run_op(1'b1, 32'h8000_0000, 32'd0, "div min/0", 0);

        // Start pulses while busy are ignored
        run_op(1'b1, 32'd1000, 32'hFFFF_FFF9, "start in calc", 5);
        run_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0, "start in done", 34);

        // Asynchronous clear mid-operation, between clock edges
        @(negedge clock);
        start = 1'b1; op = 1'b0; operand_a = 32'd7; operand_b = 32'd9;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (9) @(posedge clock);
        #3;
        clear = 1'b1;
        #1;
        check("clear busy", 64'(busy), 64'(0));
        check("clear done", 64'(done), 64'(0));
        check("clear result", {result_hi, result_lo}, 64'(0));
`ifdef MULDIV_DIV0_FLAG_EN
        check("clear flag", 64'(div_by_zero), 64'(0));
`endif
        #2;
        clear = 1'b0;
        active = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (busy === 1'b1 || done === 1'b1) active++;
        end
        check("no done after clear", 64'(active), 64'(0));
        run_op(1'b0, 32'd2, 32'd3, "mul 2*3 after clear", 0);

        // Random operands, biased toward boundary values
        for (int i = 0; i < 14; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            rb = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 4)] : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(16, 31);
            run_op(1'($urandom), ra, rb, "random", 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
